// File: rtl/sort_stream_out.sv
// Snapshots a sorted register bank on load and streams it out rank 0 first over a
// valid/ready handshake. Optional key-order checker: define SORT_ORDER_CHECK_EN.
module sort_stream_out #(
   parameter int N     = 32,
   parameter int W     = 29,
   parameter int IDX_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [N*W-1:0]   sorted_flat,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     out_data,
   output logic [IDX_W-1:0] out_index,
   output logic [IDX_W-1:0] out_rank,
   output logic             out_last,
   output logic             busy,
   output logic             done,
   output logic             overrun
`ifdef SORT_ORDER_CHECK_EN
   ,
   output logic             order_err
`endif
);

   typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

   state_t           state_q, state_d;
   logic [W-1:0]     buffer [N];
   logic [IDX_W-1:0] rank_q;
   logic [IDX_W-1:0] rank_nxt;
   logic             accept;
   logic             last_accept;

   assign accept      = (state_q == STREAM) & out_valid & out_ready;
   assign last_accept = accept & out_last;
   assign rank_nxt    = rank_q + 1'b1;
   assign out_index   = out_data[W-1 -: IDX_W];
   assign out_rank    = rank_q;

   // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (load) state_d = STREAM;
         STREAM:  if (last_accept) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // NOTE: the buffer is cleared on reset so no stale frame is ever observable after an abort.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < N; k++) buffer[k] <= '0;
      end else if (state_q == IDLE && load) begin
         for (int k = 0; k < N; k++) buffer[k] <= sorted_flat[k*W +: W];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         rank_q    <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         busy <= (state_d == STREAM);
         done <= (state_d == DONE);
         if (load && state_q != IDLE) overrun <= 1'b1;

         // Entry 0 comes straight from the input bank so it is valid one cycle after load.
         if (state_q == IDLE && load) begin
            out_valid <= 1'b1;
            out_data  <= sorted_flat[W-1:0];
            out_last  <= (N == 1);
            rank_q    <= '0;
         end else if (last_accept) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            rank_q    <= '0;
         end else if (accept) begin
            out_data  <= buffer[rank_nxt];
            out_last  <= (rank_nxt == IDX_W'(N - 1));
            rank_q    <= rank_nxt;
         end
      end
   end

`ifdef SORT_ORDER_CHECK_EN
   logic [W-IDX_W-1:0] prev_key;

   // Rank 0 has no predecessor in its frame, so the comparison restarts there.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         order_err <= 1'b0;
         prev_key  <= '0;
      end else if (accept) begin
         if (rank_q != '0 && out_data[W-IDX_W-1:0] < prev_key) order_err <= 1'b1;
         prev_key <= out_data[W-IDX_W-1:0];
      end
   end
`endif

endmodule

// File: tb/tb_sort_stream_out.sv
// Directed self-checking bench for sort_stream_out: table-driven full-throughput frame,
// stalled frame, overrun, mid-stream reset, and (with SORT_ORDER_CHECK_EN) order checking.
module tb_sort_stream_out;
   localparam int N     = 32;
   localparam int W     = 29;
   localparam int IDX_W = 5;

   logic             clk = 1'b0;
   logic             reset;
   logic             load;
   logic [N*W-1:0]   sorted_flat;
   logic             out_valid;
   logic             out_ready;
   logic [W-1:0]     out_data;
   logic [IDX_W-1:0] out_index;
   logic [IDX_W-1:0] out_rank;
   logic             out_last;
   logic             busy;
   logic             done;
   logic             overrun;
`ifdef SORT_ORDER_CHECK_EN
   logic             order_err;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sort_stream_out #(.N(N), .W(W), .IDX_W(IDX_W)) dut (
      .clk(clk), .reset(reset), .load(load), .sorted_flat(sorted_flat),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_index(out_index), .out_rank(out_rank), .out_last(out_last),
      .busy(busy), .done(done), .overrun(overrun)
`ifdef SORT_ORDER_CHECK_EN
      , .order_err(order_err)
`endif
   );

   typedef struct {
      logic         ready;
      logic         exp_valid;
      logic [4:0]   exp_rank;
      logic         exp_last;
      logic [W-1:0] exp_data;
   } vec_t;

   vec_t           vecs [N];
   logic [N*W-1:0] bank_a, bank_b, bank_c;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [W-1:0] mk_entry(input int k, input logic [7:0] key_a);
      return {5'(k), 2'b00, 6'd1, key_a, 8'd0};
   endfunction

   function automatic logic [W-1:0] entry_of(input logic [N*W-1:0] bank, input int k);
      return bank[k*W +: W];
   endfunction

   task automatic start_frame(input logic [N*W-1:0] bank);
      @(negedge clk);
      sorted_flat = bank;
      load        = 1'b1;
      @(negedge clk);
      load        = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " out_valid"}, 32'(out_valid), 0);
      check({tag, " out_data"},  32'(out_data),  0);
      check({tag, " out_index"}, 32'(out_index), 0);
      check({tag, " out_rank"},  32'(out_rank),  0);
      check({tag, " out_last"},  32'(out_last),  0);
      check({tag, " busy"},      32'(busy),      0);
      check({tag, " done"},      32'(done),      0);
   endtask

   initial begin
      int accepts;
      int exp_rank;

      for (int k = 0; k < N; k++) begin
         bank_a[k*W +: W] = mk_entry(k, 8'(k + 1));
         bank_b[k*W +: W] = mk_entry(k, 8'(k + 100));
         bank_c[k*W +: W] = mk_entry(k, (k == 6) ? 8'd4 : 8'(k + 4));
         vecs[k] = '{1'b1, 1'b1, 5'(k), (k == N - 1), mk_entry(k, 8'(k + 1))};
      end

      reset = 1'b1; load = 1'b0; out_ready = 1'b0; sorted_flat = '0;
      #12;
      check_all_zero("reset");
      check("reset overrun", 32'(overrun), 0);
      @(negedge clk);
      reset = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check_all_zero("idle");
      end

      // Frame 1: full throughput, compared against the vector table.
      out_ready = 1'b1;
      start_frame(bank_a);
      for (int i = 0; i < N; i++) begin
         out_ready = vecs[i].ready;
         check("f1 valid", 32'(out_valid), 32'(vecs[i].exp_valid));
         check("f1 rank",  32'(out_rank),  32'(vecs[i].exp_rank));
         check("f1 index", 32'(out_index), 32'(vecs[i].exp_rank));
         check("f1 last",  32'(out_last),  32'(vecs[i].exp_last));
         check("f1 data",  32'(out_data),  32'(vecs[i].exp_data));
         check("f1 busy",  32'(busy),      1);
         @(negedge clk);
      end
      check("f1 done pulse", 32'(done), 1);
      check("f1 valid low",  32'(out_valid), 0);
      check("f1 busy low",   32'(busy), 0);
      @(negedge clk);
      check("f1 done clear", 32'(done), 0);

      // Frame 2: ready pattern 1,0,0,1; data must track the model rank through stalls.
      start_frame(bank_a);
      accepts  = 0;
      exp_rank = 0;
      for (int c = 0; c < 200 && accepts < N; c++) begin
         out_ready = (c % 4 == 0) || (c % 4 == 3);
         check("f2 valid", 32'(out_valid), 1);
         check("f2 rank",  32'(out_rank), 32'(exp_rank));
         check("f2 data",  32'(out_data), 32'(entry_of(bank_a, exp_rank)));
         check("f2 last",  32'(out_last), 32'(exp_rank == N - 1));
         if (out_valid && out_ready) begin
            accepts++;
            exp_rank++;
         end
         @(negedge clk);
      end
      check("f2 accepts", 32'(accepts), 32'(N));
      check("f2 done pulse", 32'(done), 1);
      check("f2 no overrun", 32'(overrun), 0);
`ifdef SORT_ORDER_CHECK_EN
      check("ascending order_err", 32'(order_err), 0);
`endif

      // Frame 3: second load at rank 10 is ignored and flags overrun.
      out_ready = 1'b1;
      start_frame(bank_a);
      for (int i = 0; i < N; i++) begin
         load = 1'b0;
         check("f3 data", 32'(out_data), 32'(entry_of(bank_a, i)));
         if (i == 11) check("f3 overrun set", 32'(overrun), 1);
         if (i == 10) begin
            sorted_flat = bank_b;
            load        = 1'b1;
         end
         @(negedge clk);
      end
      check("f3 done pulse", 32'(done), 1);
      repeat (3) @(negedge clk);
      check("f3 overrun sticky", 32'(overrun), 1);
      reset = 1'b1;
      #1;
      check("f3 overrun cleared", 32'(overrun), 0);
      @(negedge clk);
      reset = 1'b0;

      // Frame 4: reset at rank 17 aborts asynchronously; next load restarts at rank 0.
      start_frame(bank_a);
      for (int i = 0; i < 18; i++) begin
         check("f4 rank", 32'(out_rank), 32'(i));
         if (i < 17) @(negedge clk);
      end
      reset = 1'b1;
      #1;
      check_all_zero("f4 async reset");
      @(negedge clk);
      reset = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check("f4 no done", 32'(done), 0);
      end
      start_frame(bank_b);
      for (int i = 0; i < 3; i++) begin
         check("f4 restart rank", 32'(out_rank), 32'(i));
         check("f4 restart data", 32'(out_data), 32'(entry_of(bank_b, i)));
         @(negedge clk);
      end

`ifdef SORT_ORDER_CHECK_EN
      // Frame 5: rank 6 key 0x010400 follows rank 5 key 0x010900.
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      start_frame(bank_c);
      for (int i = 0; i < 9; i++) begin
         check("f5 order_err", 32'(order_err), 32'(i >= 7));
         @(negedge clk);
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
